// File: rtl/scarv_soc_pkg.sv
// rtl/scarv_soc_pkg.sv - shared SoC memory-interface widths and payload types
package scarv_soc_pkg;

    localparam int SOC_ADDR_W = 32;
    localparam int SOC_DATA_W = 32;
    localparam int SOC_STRB_W = 4;

    typedef struct packed {
        logic                  wen;
        logic [SOC_STRB_W-1:0] strb;
        logic [SOC_ADDR_W-1:0] addr;
        logic [SOC_DATA_W-1:0] wdata;
    } memif_req_t;

    typedef struct packed {
        logic [SOC_DATA_W-1:0] rdata;
        logic                  error;
    } memif_rsp_t;

endpackage

// File: rtl/scarv_soc_memif_arb_fifo.sv
// rtl/scarv_soc_memif_arb_fifo.sv - in-order FIFO of requester IDs for response routing
module scarv_soc_memif_arb_fifo
    import scarv_soc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 1
) (
    input  logic                   f_clk,
    input  logic                   g_reset,
    input  logic                   push_i,
    input  logic [W-1:0]           push_id_i,
    input  logic                   pop_i,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointer and occupancy next state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ID storage; contents are only observed while non-empty so no reset needed.
    always_ff @(posedge f_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_id_i;
        end
    end

endmodule

// File: rtl/scarv_soc_memif_arbiter.sv
// rtl/scarv_soc_memif_arbiter.sv - round-robin sharing of one SoC memory port between NREQ masters
module scarv_soc_memif_arbiter
    import scarv_soc_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int OUTSTAND = 4
) (
    input  logic                       f_clk,
    input  logic                       g_reset,
    input  logic [NREQ-1:0]            s_req,
    output logic [NREQ-1:0]            s_gnt,
    input  logic [NREQ-1:0]            s_wen,
    input  logic [SOC_STRB_W*NREQ-1:0] s_strb,
    input  logic [SOC_ADDR_W*NREQ-1:0] s_addr,
    input  logic [SOC_DATA_W*NREQ-1:0] s_wdata,
    output logic [NREQ-1:0]            s_recv,
    input  logic [NREQ-1:0]            s_ack,
    output logic [SOC_DATA_W-1:0]      s_rdata,
    output logic                       s_error,
    output logic                       m_req,
    input  logic                       m_gnt,
    output logic                       m_wen,
    output logic [SOC_STRB_W-1:0]      m_strb,
    output logic [SOC_ADDR_W-1:0]      m_addr,
    output logic [SOC_DATA_W-1:0]      m_wdata,
    input  logic                       m_recv,
    output logic                       m_ack,
    input  logic [SOC_DATA_W-1:0]      m_rdata,
    input  logic                       m_error,
    output logic                       err_orphan
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(OUTSTAND) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(OUTSTAND);

    memif_req_t     req_arr [NREQ];
    memif_req_t     sel_req;
    memif_rsp_t     rsp;

    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           lock_q, lock_d;
    logic [IDW-1:0] lock_id_q, lock_id_d;
    logic           err_orphan_q, err_orphan_d;

    logic [IDW-1:0] rr_sel, cand, sel;
    logic           rr_found;
    logic           active, accept;

    logic           fifo_full, fifo_empty, fifo_pop;
    logic [IDW-1:0] fifo_head;
    logic [CW-1:0]  fifo_count;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign req_arr[i] = '{
            wen:   s_wen[i],
            strb:  s_strb[SOC_STRB_W*i +: SOC_STRB_W],
            addr:  s_addr[SOC_ADDR_W*i +: SOC_ADDR_W],
            wdata: s_wdata[SOC_DATA_W*i +: SOC_DATA_W]
        };
    end

    // Handshake outputs are forced low while reset is held, even mid-burst.
    assign active = ~g_reset;

    // First requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        rr_sel   = rr_ptr_q;
        rr_found = 1'b0;
        cand     = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (!rr_found && s_req[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
        end
    end

    // A stalled downstream request keeps its requester until accepted.
    assign sel     = lock_q ? lock_id_q : rr_sel;
    assign sel_req = req_arr[sel];

    assign m_req   = active & (|s_req) & ~fifo_full;
    assign m_wen   = sel_req.wen;
    assign m_strb  = sel_req.strb;
    assign m_addr  = sel_req.addr;
    assign m_wdata = sel_req.wdata;
    assign accept  = m_req & m_gnt;
    assign s_gnt   = accept ? (NREQ'(1) << sel) : '0;

    // Responses go to whoever was accepted earliest and is still unanswered.
    assign rsp      = '{rdata: m_rdata, error: m_error};
    assign s_rdata  = rsp.rdata;
    assign s_error  = rsp.error;
    assign s_recv   = (active & m_recv & ~fifo_empty) ? (NREQ'(1) << fifo_head) : '0;
    assign m_ack    = active & ~fifo_empty & s_ack[fifo_head];
    assign fifo_pop = m_recv & m_ack;

    assign err_orphan = err_orphan_q;

    // Round-robin pointer, lock and orphan-flag next state.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        lock_d       = lock_q;
        lock_id_d    = lock_id_q;
        err_orphan_d = err_orphan_q | (m_recv & fifo_empty);
        if (accept) begin
            lock_d   = 1'b0;
            rr_ptr_d = IDW'((int'(sel) + 1) % NREQ);
        end else if (m_req && (fifo_count != FULL_CNT)) begin
            lock_d    = 1'b1;
            lock_id_d = sel;
        end
    end

    // Arbitration state registers.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            rr_ptr_q     <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    scarv_soc_memif_arb_fifo #(
        .DEPTH (OUTSTAND),
        .W     (IDW)
    ) u_id_fifo (
        .f_clk     (f_clk),
        .g_reset   (g_reset),
        .push_i    (accept),
        .push_id_i (sel),
        .pop_i     (fifo_pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head),
        .count_o   (fifo_count)
    );

endmodule

// File: tb/tb_scarv_soc_memif_arbiter.sv
// tb/tb_scarv_soc_memif_arbiter.sv - self-checking bench for the memory-port arbiter
module tb_scarv_soc_memif_arbiter;

    localparam int NREQ     = 2;
    localparam int OUTSTAND = 4;

    logic        f_clk = 1'b0;
    logic        g_reset;
    logic [1:0]  s_req, s_gnt, s_wen, s_recv, s_ack;
    logic [7:0]  s_strb;
    logic [63:0] s_addr, s_wdata;
    logic [31:0] s_rdata, m_addr, m_wdata, m_rdata;
    logic        s_error, m_req, m_gnt, m_wen, m_recv, m_ack, m_error, err_orphan;
    logic [3:0]  m_strb;

    scarv_soc_memif_arbiter #(.NREQ(NREQ), .OUTSTAND(OUTSTAND)) dut (
        .f_clk(f_clk), .g_reset(g_reset),
        .s_req(s_req), .s_gnt(s_gnt), .s_wen(s_wen), .s_strb(s_strb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_recv(s_recv), .s_ack(s_ack),
        .s_rdata(s_rdata), .s_error(s_error),
        .m_req(m_req), .m_gnt(m_gnt), .m_wen(m_wen), .m_strb(m_strb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_recv(m_recv), .m_ack(m_ack),
        .m_rdata(m_rdata), .m_error(m_error), .err_orphan(err_orphan)
    );

    always #5 f_clk = ~f_clk;

    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: queue of issuer IDs in acceptance order plus arbitration state.
    int   mdl_q[$];
    int   mdl_rr = 0;
    bit   mdl_locked = 0;
    int   mdl_lock_id = 0;
    bit   mdl_orph = 0;

    logic [1:0]  last_gnt, obs_gnt, obs_recv;
    logic        obs_mreq, obs_mack, obs_orph;
    logic [31:0] obs_rdata, obs_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: predict, check mid-cycle, advance the model, cross the edge.
    task automatic step(input string tag);
        int         sel, head;
        bit         found, full, e_mreq, acc, e_mack;
        logic [1:0] e_gnt, e_recv;
        full = (mdl_q.size() == OUTSTAND);
        sel = 0;
        found = 0;
        if (mdl_locked) sel = mdl_lock_id;
        else begin
            for (int k = 0; k < NREQ; k++) begin
                int c;
                c = (mdl_rr + k) % NREQ;
                if (!found && s_req[c]) begin found = 1; sel = c; end
            end
        end
        e_mreq = !g_reset && (s_req != 2'b00) && !full;
        acc    = e_mreq && m_gnt;
        e_gnt  = acc ? 2'(1 << sel) : 2'b00;
        head   = (mdl_q.size() > 0) ? mdl_q[0] : -1;
        e_recv = (!g_reset && m_recv && head >= 0) ? 2'(1 << head) : 2'b00;
        e_mack = !g_reset && head >= 0 && s_ack[head];
        #4;
        obs_gnt = s_gnt; obs_recv = s_recv; obs_mreq = m_req; obs_mack = m_ack;
        obs_rdata = s_rdata; obs_addr = m_addr; obs_orph = err_orphan;
        chk({tag, ":m_req"}, m_req, e_mreq);
        chk({tag, ":s_gnt"}, s_gnt, e_gnt);
        chk({tag, ":s_recv"}, s_recv, e_recv);
        chk({tag, ":m_ack"}, m_ack, e_mack);
        chk({tag, ":err_orphan"}, err_orphan, mdl_orph);
        chk({tag, ":s_rdata"}, s_rdata, m_rdata);
        chk({tag, ":s_error"}, s_error, m_error);
        if (e_mreq) begin
            chk({tag, ":m_addr"}, m_addr, s_addr[32*sel +: 32]);
            chk({tag, ":m_wdata"}, m_wdata, s_wdata[32*sel +: 32]);
            chk({tag, ":m_strb"}, m_strb, s_strb[4*sel +: 4]);
            chk({tag, ":m_wen"}, m_wen, s_wen[sel]);
        end
        last_gnt = e_gnt;
        if (g_reset) begin
            mdl_q.delete();
            mdl_rr = 0; mdl_locked = 0; mdl_lock_id = 0; mdl_orph = 0;
        end else begin
            if (m_recv && head < 0) mdl_orph = 1;
            if (m_recv && e_mack) void'(mdl_q.pop_front());
            if (acc) begin
                mdl_q.push_back(sel);
                mdl_rr = (sel + 1) % NREQ;
                mdl_locked = 0;
            end else if (e_mreq) begin
                mdl_locked = 1;
                mdl_lock_id = sel;
            end
        end
        @(posedge f_clk);
        #1;
    endtask

    // Requesters drop after their grant and may raise a fresh request with new payload.
    task automatic rand_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (last_gnt[i]) s_req[i] = 1'b0;
            if (!s_req[i] && $urandom_range(0, 1) == 1) begin
                s_req[i] = 1'b1;
                s_wen[i] = 1'($urandom);
                s_strb[4*i +: 4] = 4'($urandom);
                s_addr[32*i +: 32] = $urandom;
                s_wdata[32*i +: 32] = $urandom;
            end
        end
    endtask

    task automatic drain();
        s_req = 2'b00; m_gnt = 1'b0; m_recv = 1'b1; s_ack = 2'b11;
        for (int n = 0; n < 20 && mdl_q.size() > 0; n++) step("drain");
        m_recv = 1'b0;
    endtask

    initial begin
        g_reset = 1'b1; s_req = 0; s_wen = 2'b01; s_strb = 8'h3F; s_ack = 0;
        s_addr = {32'h2000_0004, 32'h1000_0000}; s_wdata = {32'hBBBB_0001, 32'hAAAA_0000};
        m_gnt = 0; m_recv = 0; m_rdata = 0; m_error = 0; last_gnt = 0;
        @(posedge f_clk); #1;
        step("rst0"); step("rst1");
        g_reset = 1'b0;

        // Reset in the middle of a burst.
        s_req = 2'b11; m_gnt = 1'b1;
        step("burst0");
        step("burst1");
        g_reset = 1'b1;
        step("midrst0");
        chk("midrst_mreq", obs_mreq, 1'b0);
        step("midrst1");
        chk("midrst_gnt", obs_gnt, 2'b00);
        g_reset = 1'b0;
        step("postrst");
        chk("postrst_gnt0", obs_gnt, 2'b01);
        drain();

        // Alternating grants with both requesting, then full and refill.
        g_reset = 1'b1; step("rst2"); g_reset = 1'b0;
        s_req = 2'b11; m_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step("alt");
            chk("alt_gnt", obs_gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
        step("full");
        chk("full_mreq", obs_mreq, 1'b0);
        m_recv = 1'b1; s_ack = 2'b11;
        for (int k = 0; k < 4; k++) begin
            step("order");
            chk("order_recv", obs_recv, (k % 2 == 0) ? 2'b01 : 2'b10);
            if (k == 1) chk("refill_mreq", obs_mreq, 1'b1);
        end
        drain();

        // Stalled downstream request locks the selection to requester 0.
        s_req = 2'b01; m_gnt = 1'b0;
        step("lock0");
        chk("lock0_addr", obs_addr, 32'h1000_0000);
        s_req = 2'b11;
        step("lock1");
        chk("lock1_addr", obs_addr, 32'h1000_0000);
        step("lock2");
        chk("lock2_addr", obs_addr, 32'h1000_0000);
        m_gnt = 1'b1;
        step("lock_gnt");
        chk("lock_gnt0", obs_gnt, 2'b01);
        s_req = 2'b10;
        step("lock_after");
        drain();

        // Responses routed in acceptance order, with a stalled acknowledge.
        s_addr = {32'h1000_1000, 32'h1000_0000};
        s_req = 2'b01; m_gnt = 1'b1;
        step("ro_acc0");
        s_req = 2'b10;
        step("ro_acc1");
        s_req = 2'b00; m_gnt = 1'b0;
        m_recv = 1'b1; m_rdata = 32'hA; s_ack = 2'b00;
        for (int k = 0; k < 2; k++) begin
            step("ro_stall");
            chk("ro_stall_mack", obs_mack, 1'b0);
            chk("ro_stall_recv", obs_recv, 2'b01);
        end
        s_ack = 2'b01;
        step("ro_rsp0");
        chk("ro_rsp0_rdata", obs_rdata, 32'hA);
        chk("ro_rsp0_mack", obs_mack, 1'b1);
        m_rdata = 32'hB; s_ack = 2'b10;
        step("ro_rsp1");
        chk("ro_rsp1_recv", obs_recv, 2'b10);
        chk("ro_rsp1_rdata", obs_rdata, 32'hB);
        m_recv = 1'b0;

        // Orphan response with nothing outstanding.
        m_recv = 1'b1; s_ack = 2'b11;
        step("orph");
        chk("orph_recv", obs_recv, 2'b00);
        chk("orph_mack", obs_mack, 1'b0);
        m_recv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step("orph_hold");
            chk("orph_sticky", obs_orph, 1'b1);
        end
        g_reset = 1'b1; step("orph_rst"); g_reset = 1'b0;
        step("orph_clr");
        chk("orph_cleared", obs_orph, 1'b0);

        // Randomized traffic against the model.
        s_req = 2'b00; last_gnt = 2'b00;
        for (int n = 0; n < 600; n++) begin
            rand_reqs();
            m_gnt   = ($urandom_range(0, 3) != 0);
            m_recv  = (mdl_q.size() > 0) && ($urandom_range(0, 1) == 1);
            m_rdata = $urandom;
            m_error = 1'($urandom);
            s_ack   = 2'($urandom);
            step("rnd");
        end

        // Reset with transactions in flight; the late response is an orphan.
        s_req = 2'b11; m_gnt = 1'b1; m_recv = 1'b0;
        step("inflight0");
        step("inflight1");
        g_reset = 1'b1; s_req = 2'b00;
        step("inflight_rst0"); step("inflight_rst1");
        g_reset = 1'b0; m_recv = 1'b1;
        step("late_rsp");
        chk("late_rsp_recv", obs_recv, 2'b00);
        m_recv = 1'b0;
        step("late_orph");
        chk("late_orph_flag", obs_orph, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
